// File: rtl/vga_timing_gen_pkg.sv
// vga_pkg: 640x480@60 timing defaults, coordinate width, lock FSM states and the
// registered raster output bundle shared by vga_timing_gen and its lock sub-module.
package vga_pkg;
    localparam int COORD_W    = 12;
    localparam int H_ACTIVE_D = 640;
    localparam int H_FP_D     = 16;
    localparam int H_SYNC_D   = 96;
    localparam int H_BP_D     = 48;
    localparam int V_ACTIVE_D = 480;
    localparam int V_FP_D     = 10;
    localparam int V_SYNC_D   = 2;
    localparam int V_BP_D     = 33;

    typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} lock_state_t;

    typedef struct packed {
        logic               hsync;
        logic               vsync;
        logic               de;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               line_start;
        logic               frame_start;
    } vga_out_t;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic vga_out_t idle_out(input logic hs_pol, input logic vs_pol);
        vga_out_t o;
        o       = '0;
        o.hsync = ~hs_pol;
        o.vsync = ~vs_pol;
        return o;
    endfunction
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster outputs of vga_timing_gen; the fetch signals exist only
// when VGA_TIMING_PREFETCH_EN is defined.
interface vga_timing_gen_if;
    logic                        running;
    logic                        hsync;
    logic                        vsync;
    logic                        de;
    logic [vga_pkg::COORD_W-1:0] x;
    logic [vga_pkg::COORD_W-1:0] y;
    logic                        line_start;
    logic                        frame_start;
`ifdef VGA_TIMING_PREFETCH_EN
    logic                        fetch_req;
    logic [vga_pkg::COORD_W-1:0] fetch_x;
    logic [vga_pkg::COORD_W-1:0] fetch_y;
    modport master(output running, hsync, vsync, de, x, y, line_start, frame_start, fetch_req, fetch_x, fetch_y);
    modport slave(input running, hsync, vsync, de, x, y, line_start, frame_start, fetch_req, fetch_x, fetch_y);
`else
    modport master(output running, hsync, vsync, de, x, y, line_start, frame_start);
    modport slave(input running, hsync, vsync, de, x, y, line_start, frame_start);
`endif
endinterface

// File: rtl/vga_lock_sync.sv
// vga_lock_sync: synchronises pll_lock and requires LOCK_WAIT consecutive locked cycles
// before o_lock_ok rises; o_lock_ok drops as soon as the synchronised lock drops.
module vga_lock_sync import vga_pkg::*; #(
    parameter int LOCK_WAIT = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_pll_lock,
    output logic o_lock_ok
);
    logic [1:0]  r_sync;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_nxt;
    lock_state_t r_state;
    lock_state_t w_state_nxt;
    logic        w_lock_s;

    assign w_lock_s = r_sync[1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync  <= '0;
            r_state <= WAIT_LOCK;
            r_cnt   <= '0;
        end else begin
            r_sync  <= {r_sync[0], i_pll_lock};
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        if (!w_lock_s) begin
            w_state_nxt = WAIT_LOCK;
        end else if (r_state == WAIT_LOCK) begin
            w_state_nxt = SETTLE;
        end else if (r_state == SETTLE) begin
            w_state_nxt = (r_cnt == 8'(LOCK_WAIT - 1)) ? RUN : SETTLE;
            w_cnt_nxt   = r_cnt + 8'd1;
        end
    end

    // gating with the synchronised level shortens the lock-loss path by one cycle
    assign o_lock_ok = (r_state == RUN) && w_lock_s;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing held idle until the PLL lock is stable.
// Define VGA_TIMING_PREFETCH_EN to run the counters PREFETCH cycles ahead and expose fetch outputs.
module vga_timing_gen import vga_pkg::*; #(
`ifdef VGA_TIMING_PREFETCH_EN
    parameter int PREFETCH  = 2,
`endif
    parameter int H_ACTIVE  = H_ACTIVE_D,
    parameter int H_FP      = H_FP_D,
    parameter int H_SYNC    = H_SYNC_D,
    parameter int H_BP      = H_BP_D,
    parameter int V_ACTIVE  = V_ACTIVE_D,
    parameter int V_FP      = V_FP_D,
    parameter int V_SYNC    = V_SYNC_D,
    parameter int V_BP      = V_BP_D,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int LOCK_WAIT = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             pll_lock,
    vga_timing_gen_if.master bus
);
    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam logic [COORD_W-1:0] HA  = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] HS0 = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS1 = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] HT1 = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] VA  = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] VS0 = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS1 = COORD_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [COORD_W-1:0] VT1 = COORD_W'(V_TOTAL - 1);
    localparam vga_out_t IDLE = idle_out(HS_POL, VS_POL);

    logic               w_lock_ok;
    logic [COORD_W-1:0] r_hcnt;
    logic [COORD_W-1:0] r_vcnt;
    logic               w_h_wrap;
    logic               w_v_wrap;
    vga_out_t           w_nxt;
    vga_out_t           w_disp;

    vga_lock_sync #(.LOCK_WAIT(LOCK_WAIT)) u_lock (
        .clk        (clk),
        .resetn     (resetn),
        .i_pll_lock (pll_lock),
        .o_lock_ok  (w_lock_ok)
    );

    assign w_h_wrap = (r_hcnt == HT1);
    assign w_v_wrap = (r_vcnt == VT1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else begin
            r_hcnt <= (!w_lock_ok || w_h_wrap) ? '0 : r_hcnt + 1'b1;
            r_vcnt <= !w_lock_ok ? '0 : !w_h_wrap ? r_vcnt : w_v_wrap ? '0 : r_vcnt + 1'b1;
        end
    end

    always_comb begin
        w_nxt = IDLE;
        if (w_lock_ok) begin
            w_nxt.hsync       = (r_hcnt >= HS0 && r_hcnt < HS1) ? HS_POL : ~HS_POL;
            w_nxt.vsync       = (r_vcnt >= VS0 && r_vcnt < VS1) ? VS_POL : ~VS_POL;
            w_nxt.de          = (r_hcnt < HA) && (r_vcnt < VA);
            w_nxt.x           = r_hcnt;
            w_nxt.y           = r_vcnt;
            w_nxt.line_start  = (r_hcnt == '0) && (r_vcnt < VA);
            w_nxt.frame_start = (r_hcnt == '0) && (r_vcnt == '0);
        end
    end

`ifdef VGA_TIMING_PREFETCH_EN
    vga_out_t r_pipe [0:PREFETCH];

    // stage 0 is the fetch view; the whole pipe clears together when the raster stops
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i <= PREFETCH; i++) r_pipe[i] <= IDLE;
        end else begin
            r_pipe[0] <= w_nxt;
            for (int i = 1; i <= PREFETCH; i++) r_pipe[i] <= w_lock_ok ? r_pipe[i-1] : IDLE;
        end
    end

    assign w_disp        = r_pipe[PREFETCH];
    assign bus.fetch_req = r_pipe[0].de;
    assign bus.fetch_x   = r_pipe[0].x;
    assign bus.fetch_y   = r_pipe[0].y;
`else
    vga_out_t r_out;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_out <= IDLE;
        else         r_out <= w_nxt;
    end

    assign w_disp = r_out;
`endif

    assign bus.running     = w_lock_ok;
    assign bus.hsync       = w_disp.hsync;
    assign bus.vsync       = w_disp.vsync;
    assign bus.de          = w_disp.de;
    assign bus.x           = w_disp.x;
    assign bus.y           = w_disp.y;
    assign bus.line_start  = w_disp.line_start;
    assign bus.frame_start = w_disp.frame_start;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen on a reduced 32x15 raster
// covering lock settle, free run, lock loss, asynchronous reset and optional prefetch.
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam int HA = 16, HF = 4, HS = 6, HB = 6, HT = HA + HF + HS + HB;
    localparam int VA = 8, VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;
    localparam int LW = 16;
`ifdef VGA_TIMING_PREFETCH_EN
    localparam int PF  = 2;
    localparam int LAT = 1 + PF;
`else
    localparam int LAT = 1;
`endif
    localparam logic [31:0] IDLE_V = {2'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24'd0, 2'b00};

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic pll_lock = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    int c;
    int hs_n, vs_n, de_n, last_fs, last_ls;
    logic prev_hs, prev_vs, prev_de;

    vga_timing_gen_if vif();

    vga_timing_gen #(
`ifdef VGA_TIMING_PREFETCH_EN
        .PREFETCH(PF),
`endif
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .LOCK_WAIT(LW)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .pll_lock (pll_lock),
        .bus      (vif)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] obs();
        return {2'b0, vif.running, vif.hsync, vif.vsync, vif.de, vif.x, vif.y, vif.line_start, vif.frame_start};
    endfunction

    // expected outputs c cycles after running was first seen high
    function automatic logic [31:0] model(input int cyc);
        int k, h, v;
        if (cyc < LAT) return IDLE_V | 32'h2000_0000;
        k = cyc - LAT;
        h = k % HT;
        v = (k / HT) % VT;
        return {2'b0, 1'b1, !(h >= HA + HF && h < HA + HF + HS), !(v >= VA + VF && v < VA + VF + VS),
                (h < HA && v < VA), 12'(h), 12'(v), (h == 0 && v < VA), (h == 0 && v == 0)};
    endfunction

    task automatic reset_meas();
        c = 0; hs_n = 0; vs_n = 0; de_n = 0; last_fs = -1; last_ls = -1;
        prev_hs = 1'b1; prev_vs = 1'b1; prev_de = 1'b0;
    endtask

    task automatic wait_run(input string tag);
        int n;
        n = 0;
        while (!vif.running && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(tag, (n >= LW + 1 && n <= LW + 3) ? 32'(LW + 2) : 32'(n), 32'(LW + 2));
        reset_meas();
    endtask

    task automatic run(input int n, input string tag);
`ifdef VGA_TIMING_PREFETCH_EN
        logic [31:0] mf;
`endif
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(model(c));
            chk(tag, obs(), exp_q.pop_front());
`ifdef VGA_TIMING_PREFETCH_EN
            mf = model(c - 1 + LAT);
            chk("fetch", 32'({vif.fetch_req, vif.fetch_x, vif.fetch_y}), c < 1 ? 32'd0 : {7'd0, mf[26:2]});
`endif
            if (c >= LAT) begin
                if (!vif.hsync) begin
                    if (prev_hs) chk("hs_start_x", 32'(vif.x), HA + HF);
                    hs_n++;
                end else begin
                    if (!prev_hs) chk("hs_width", hs_n, HS);
                    hs_n = 0;
                end
                if (!vif.vsync) begin
                    if (prev_vs) chk("vs_start", 32'({vif.x, vif.y}), 32'(VA + VF));
                    vs_n++;
                end else begin
                    if (!prev_vs) chk("vs_width", vs_n, VS * HT);
                    vs_n = 0;
                end
                if (vif.de) de_n++;
                else begin
                    if (prev_de) chk("de_width", de_n, HA);
                    de_n = 0;
                end
                if (vif.frame_start) begin
                    if (last_fs >= 0) chk("fs_period", c - last_fs, HT * VT);
                    last_fs = c;
                end
                if (vif.line_start) begin
                    if (last_ls >= 0 && vif.y != '0) chk("ls_period", c - last_ls, HT);
                    last_ls = c;
                end
                prev_hs = vif.hsync;
                prev_vs = vif.vsync;
                prev_de = vif.de;
            end
            c++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        reset_meas();
        repeat (3) @(negedge clk);
        chk("reset", obs(), IDLE_V);
        resetn = 1'b1;
        pll_lock = 1'b1;
        repeat (10) @(negedge clk);
        pll_lock = 1'b0;
        repeat (6) @(negedge clk);
        chk("settle_abort", 32'(vif.running), 32'd0);
        pll_lock = 1'b1;
        wait_run("lock_lat");
        run(2 * HT * VT + 5 * HT + 21 + LAT, "frame");
        pll_lock = 1'b0;
        n = 0;
        while (obs() != IDLE_V && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("drop_lat", (n >= 1 && n <= 3) ? 32'd3 : 32'(n), 32'd3);
        chk("drop_idle", obs(), IDLE_V);
`ifdef VGA_TIMING_PREFETCH_EN
        chk("drop_fetch", 32'({vif.fetch_req, vif.fetch_x, vif.fetch_y}), 32'd0);
`endif
        repeat (4) @(negedge clk);
        pll_lock = 1'b1;
        wait_run("relock_lat");
        run(3 * HT + 10 + LAT, "restart");
        resetn = 1'b0;
        #1;
        chk("async_rst", obs(), IDLE_V);
        @(negedge clk);
        resetn = 1'b1;
        wait_run("reset_lat");
        run(HT * VT + HT + LAT, "after_rst");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
